mmcm_rst_seq: RTL and testbench
===============================

MMCM_RST_SEQ -- requirements
Module: mmcm_rst_seq

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 8: number of cycles MMCM_RST is held high per reset attempt (legal range 1-255).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYC, default 20000: cycles to wait for lock before retrying (100 us at 200 MHz).
REQ-003 SHALL have parameter STABLE_CYC, default 256: consecutive locked cycles required before downstream reset release.
REQ-004 SHALL have parameter MAX_RETRY, default 4: failed attempts allowed before fault (range 1-15).
REQ-005 SHALL have port CLKIN1, input, 1 bit: the single clock, the same 200 MHz clock that drives the MMCM.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous to CLKIN1, active-high.
REQ-007 SHALL have port LOCKED, input, 1 bit: MMCM lock indication, asynchronous to CLKIN1.
REQ-008 SHALL have port MMCM_RST, output, 1 bit: reset to the MMCM, active-high.
REQ-009 SHALL have port RST_OUT, output, 1 bit: reset for logic on the MMCM output clocks, active-high.
REQ-010 SHALL have port READY, output, 1 bit: MMCM locked and stable.
REQ-011 SHALL have port FAULT, output, 1 bit: retry budget exhausted.
REQ-012 SHALL have port RETRY_CNT, output, 4 bits: failed attempts since the last entry to RUN.
REQ-013 SHALL have port LOSS_CNT, output, 8 bits: lock losses seen while in RUN, saturating at 255.

Function
REQ-014 SHALL pass LOCKED through a 2-flop synchronizer; locked_s lags LOCKED by 2 cycles, and all decisions SHALL use locked_s only.
REQ-015 SHALL implement the states RESET, WAIT_LOCK, STABLE, RUN and FAULT, with one shared cycle counter that is cleared on every state entry.
REQ-016 In RESET: MMCM_RST=1, RST_OUT=1, READY=0; after exactly RST_PULSE_CYC cycles, go to WAIT_LOCK.
REQ-017 In WAIT_LOCK: MMCM_RST=0, RST_OUT=1.
  - locked_s=1: go to STABLE.
  - LOCK_TIMEOUT_CYC cycles elapsed without lock: count a failure (REQ-020).
REQ-018 In STABLE: MMCM_RST=0, RST_OUT=1.
  - Count consecutive locked_s=1 cycles; on reaching STABLE_CYC, go to RUN.
  - locked_s=0: count a failure.
  - If locked_s=0 in the same cycle the count completes, the failure SHALL win.
REQ-019 In RUN: RST_OUT=0, READY=1, MMCM_RST=0.
  - All three values are valid in the first RUN cycle, because outputs are registered from the next state.
  - RETRY_CNT is cleared on RUN entry.
  - locked_s=0: increment LOSS_CNT (saturating) and go to RESET; RST_OUT=1 and READY=0 from the next cycle.
  - A RUN lock loss SHALL NOT count as a failure.
REQ-020 On a failure:
  - Increment RETRY_CNT.
  - If the new value equals MAX_RETRY, go to FAULT; otherwise go to RESET.
REQ-021 FAULT SHALL be terminal until RST: MMCM_RST=1, RST_OUT=1, READY=0, FAULT=1, and RETRY_CNT held at MAX_RETRY.
REQ-022 All outputs SHALL be registered and glitch-free; RST_OUT SHALL never be 0 while MMCM_RST=1.
REQ-023 Counter width SHALL be sized from the largest of RST_PULSE_CYC, LOCK_TIMEOUT_CYC and STABLE_CYC; the counter SHALL never wrap.

Reset
REQ-024 While RST=1, the block SHALL force:
  - state RESET with the counter cleared;
  - MMCM_RST=1, RST_OUT=1;
  - READY=0, FAULT=0;
  - RETRY_CNT=0, LOSS_CNT=0;
  - synchronizer flops cleared to 0.
REQ-025 RST asserted in any state, including FAULT or mid-count, SHALL take effect on the next clock edge and override every other transition.
REQ-026 After RST falls, MMCM_RST SHALL remain 1 for exactly RST_PULSE_CYC further cycles.

Verification (bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=50, STABLE_CYC=16, MAX_RETRY=3)
REQ-027 Nominal bring-up: RST falls, then LOCKED=1 20 cycles later and held.
  - MMCM_RST=1 for 4 cycles, then 0.
  - RST_OUT falls exactly 2+16 cycles after LOCKED rises (plus entry cycle), with READY=1.
  - RETRY_CNT=0.
REQ-028 Lock timeout to fault: LOCKED held at 0.
  - MMCM_RST pulses 3 times (4 cycles each), 50 cycles apart.
  - RETRY_CNT steps 1, 2, 3.
  - FAULT=1 with MMCM_RST=1 held permanently; RST then clears everything to reset values.
REQ-029 Glitch during STABLE: LOCKED drops for 1 cycle at stable count 10, including the case where the drop coincides with count 16.
  - RETRY_CNT=1 and a new 4-cycle MMCM_RST pulse is issued.
  - RST_OUT stays 1 throughout.
REQ-030 Lock loss in RUN: LOCKED falls for 5 cycles.
  - RST_OUT=1 and READY=0 three cycles after the fall.
  - LOSS_CNT=1, RETRY_CNT=0.
  - Re-lock returns to RUN after 16 stable cycles.
  - 300 repeated losses leave LOSS_CNT=255.
REQ-031 RST mid-WAIT_LOCK (cycle 30) with RETRY_CNT=2: on the next edge MMCM_RST=1 and RETRY_CNT=0, and the sequence restarts exactly as in REQ-027.

Source files
------------

// File: rtl/mmcm_rst_seq.sv
// rtl/mmcm_rst_seq.sv - MMCM reset/lock sequencer with timeout retry, stability filter and fault latch
// Drives MMCM_RST, holds downstream reset until lock has been stable, retries on timeout or glitch.
module mmcm_rst_seq #(
    parameter int RST_PULSE_CYC    = 8,
    parameter int LOCK_TIMEOUT_CYC = 20000,
    parameter int STABLE_CYC       = 256,
    parameter int MAX_RETRY        = 4
) (
    input  logic       CLKIN1,
    input  logic       RST,
    input  logic       LOCKED,
    output logic       MMCM_RST,
    output logic       RST_OUT,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_nxt_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nxt_cnt;
    logic [3:0]    r_retry;
    logic [3:0]    w_nxt_retry;
    logic [3:0]    w_retry_inc;
    logic [7:0]    r_loss;
    logic [7:0]    w_nxt_loss;
    logic          w_fail;
    logic          r_sync1;
    logic          r_locked_s;
    logic          r_mmcm_rst;
    logic          r_rst_out;
    logic          r_ready;
    logic          r_fault;

    assign w_retry_inc = r_retry + 4'd1;

    // Counter only advances while a state is still waiting on its terminal count,
    // so it can never wrap regardless of how long RUN or FAULT persist.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_retry = r_retry;
        w_nxt_loss  = r_loss;
        w_fail      = 1'b0;
        case (r_state)
            S_RESET: begin
                if (r_cnt == PULSE_LAST) w_nxt_state = S_WAIT_LOCK;
                else                     w_nxt_cnt   = r_cnt + CW'(1);
            end
            S_WAIT_LOCK: begin
                if (r_locked_s)                  w_nxt_state = S_STABLE;
                else if (r_cnt == TIMEOUT_LAST)  w_fail      = 1'b1;
                else                             w_nxt_cnt   = r_cnt + CW'(1);
            end
            S_STABLE: begin
                // Checking lock first makes a drop on the completing cycle a failure.
                if (!r_locked_s)                w_fail      = 1'b1;
                else if (r_cnt == STABLE_LAST)  w_nxt_state = S_RUN;
                else                            w_nxt_cnt   = r_cnt + CW'(1);
            end
            S_RUN: begin
                if (!r_locked_s) begin
                    w_nxt_state = S_RESET;
                    if (r_loss != 8'hFF) w_nxt_loss = r_loss + 8'd1;
                end
            end
            S_FAULT: begin
                w_nxt_state = S_FAULT;
            end
            default: begin
                w_nxt_state = S_RESET;
            end
        endcase

        if (w_fail) begin
            w_nxt_retry = w_retry_inc;
            w_nxt_state = (w_retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET;
        end
        if (w_nxt_state != r_state) w_nxt_cnt = '0;
        if (w_nxt_state == S_RUN && r_state != S_RUN) w_nxt_retry = 4'd0;
    end

    // Outputs are registered from the next state so they are valid in a state's first cycle.
    always_ff @(posedge CLKIN1) begin
        if (RST) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_retry    <= 4'd0;
            r_loss     <= 8'd0;
            r_mmcm_rst <= 1'b1;
            r_rst_out  <= 1'b1;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_sync1    <= LOCKED;
            r_locked_s <= r_sync1;
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_retry    <= w_nxt_retry;
            r_loss     <= w_nxt_loss;
            r_mmcm_rst <= (w_nxt_state == S_RESET) || (w_nxt_state == S_FAULT);
            r_rst_out  <= (w_nxt_state != S_RUN);
            r_ready    <= (w_nxt_state == S_RUN);
            r_fault    <= (w_nxt_state == S_FAULT);
        end
    end

    assign MMCM_RST  = r_mmcm_rst;
    assign RST_OUT   = r_rst_out;
    assign READY     = r_ready;
    assign FAULT     = r_fault;
    assign RETRY_CNT = r_retry;
    assign LOSS_CNT  = r_loss;

endmodule

// File: tb/tb_mmcm_rst_seq.sv
// tb/tb_mmcm_rst_seq.sv - scoreboard bench for mmcm_rst_seq with directed bring-up, retry, fault and loss vectors
module tb_mmcm_rst_seq;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       mmcm_rst;
    logic       rst_out;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int          cyc;
        string       nm;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];

    mmcm_rst_seq #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(50),
        .STABLE_CYC      (16),
        .MAX_RETRY       (3)
    ) dut (
        .CLKIN1   (clk),
        .RST      (rst),
        .LOCKED   (locked),
        .MMCM_RST (mmcm_rst),
        .RST_OUT  (rst_out),
        .READY    (ready),
        .FAULT    (fault),
        .RETRY_CNT(retry_cnt),
        .LOSS_CNT (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
        $fatal(1, "watchdog expired");
    end

    // Monitor: every cycle, retire all expectations scheduled for this cycle.
    always @(negedge clk) begin
        logic [15:0] got;
        exp_t        e;
        got = {mmcm_rst, rst_out, ready, fault, retry_cnt, loss_cnt};
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || got !== e.v) begin
                n_miss++;
                $display("FAIL %s cyc=%0d (sched %0d) got mr=%0b ro=%0b rdy=%0b flt=%0b retry=%0d loss=%0d want mr=%0b ro=%0b rdy=%0b flt=%0b retry=%0d loss=%0d",
                         e.nm, cyc, e.cyc, got[15], got[14], got[13], got[12], got[11:8], got[7:0],
                         e.v[15], e.v[14], e.v[13], e.v[12], e.v[11:8], e.v[7:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int off, input string nm, input bit mr, input bit ro,
                          input bit rdy, input bit flt, input int rc, input int lc);
        exp_t e;
        e.cyc = cyc + off;
        e.nm  = nm;
        e.v   = {mr, ro, rdy, flt, 4'(rc), 8'(lc)};
        q.push_back(e);
    endtask

    task automatic do_reset(input bit lk);
        rst    = 1'b1;
        locked = lk;
        step(3);
        exp_at(0, "reset_state", 1, 1, 0, 0, 0, 0);
    endtask

    // Called with RST high, LOCKED low, reset state at current cycle; ends in RUN at +40.
    task automatic nominal();
        exp_at(3,  "nom_pulse_last", 1, 1, 0, 0, 0, 0);
        exp_at(4,  "nom_pulse_end",  0, 1, 0, 0, 0, 0);
        exp_at(38, "nom_pre_run",    0, 1, 0, 0, 0, 0);
        exp_at(39, "nom_run",        0, 0, 1, 0, 0, 0);
        rst = 1'b0;
        step(20);
        locked = 1'b1;
        step(20);
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;

        // Nominal bring-up, then a 5-cycle lock loss in RUN
        do_reset(0);
        nominal();
        exp_at(2,  "loss_still_run", 0, 0, 1, 0, 0, 0);
        exp_at(3,  "loss_reset",     1, 1, 0, 0, 0, 1);
        exp_at(7,  "loss_wait",      0, 1, 0, 0, 0, 1);
        exp_at(23, "loss_pre_run",   0, 1, 0, 0, 0, 1);
        exp_at(24, "loss_rerun",     0, 0, 1, 0, 0, 1);
        locked = 1'b0;
        step(5);
        locked = 1'b1;
        step(21);

        // Glitch at stable count 10
        do_reset(1);
        exp_at(4,  "g10_wait",     0, 1, 0, 0, 0, 0);
        exp_at(15, "g10_stable",   0, 1, 0, 0, 0, 0);
        exp_at(16, "g10_fail",     1, 1, 0, 0, 1, 0);
        exp_at(19, "g10_pulse",    1, 1, 0, 0, 1, 0);
        exp_at(20, "g10_wait2",    0, 1, 0, 0, 1, 0);
        exp_at(36, "g10_pre_run",  0, 1, 0, 0, 1, 0);
        exp_at(37, "g10_run",      0, 0, 1, 0, 0, 0);
        rst = 1'b0;
        step(13);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(25);

        // Glitch on the cycle the stable count would complete
        do_reset(1);
        exp_at(19, "g16_stable14", 0, 1, 0, 0, 0, 0);
        exp_at(20, "g16_stable15", 0, 1, 0, 0, 0, 0);
        exp_at(21, "g16_fail",     1, 1, 0, 0, 1, 0);
        exp_at(25, "g16_wait2",    0, 1, 0, 0, 1, 0);
        exp_at(41, "g16_pre_run",  0, 1, 0, 0, 1, 0);
        exp_at(42, "g16_run",      0, 0, 1, 0, 0, 0);
        rst = 1'b0;
        step(18);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(25);

        // Lock timeout to fault, fault is terminal until RST
        do_reset(0);
        exp_at(4,   "to_wait1",     0, 1, 0, 0, 0, 0);
        exp_at(53,  "to_wait1_end", 0, 1, 0, 0, 0, 0);
        exp_at(54,  "to_retry1",    1, 1, 0, 0, 1, 0);
        exp_at(57,  "to_pulse1",    1, 1, 0, 0, 1, 0);
        exp_at(58,  "to_wait2",     0, 1, 0, 0, 1, 0);
        exp_at(107, "to_wait2_end", 0, 1, 0, 0, 1, 0);
        exp_at(108, "to_retry2",    1, 1, 0, 0, 2, 0);
        exp_at(111, "to_pulse2",    1, 1, 0, 0, 2, 0);
        exp_at(112, "to_wait3",     0, 1, 0, 0, 2, 0);
        exp_at(161, "to_wait3_end", 0, 1, 0, 0, 2, 0);
        exp_at(162, "to_fault",     1, 1, 0, 1, 3, 0);
        exp_at(229, "to_fault_hold",1, 1, 0, 1, 3, 0);
        rst = 1'b0;
        step(170);
        locked = 1'b1;
        step(60);
        rst = 1'b1;
        step(1);
        exp_at(0, "fault_clear", 1, 1, 0, 0, 0, 0);

        // RST in WAIT_LOCK cycle 30 with two failures recorded
        do_reset(0);
        exp_at(54,  "mid_retry1", 1, 1, 0, 0, 1, 0);
        exp_at(108, "mid_retry2", 1, 1, 0, 0, 2, 0);
        exp_at(112, "mid_wait3",  0, 1, 0, 0, 2, 0);
        exp_at(142, "mid_wait30", 0, 1, 0, 0, 2, 0);
        rst = 1'b0;
        step(142);
        rst = 1'b1;
        step(1);
        exp_at(0, "mid_rst", 1, 1, 0, 0, 0, 0);
        nominal();

        // Repeated RUN losses saturate LOSS_CNT
        do_reset(0);
        nominal();
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            step(1);
            locked = 1'b1;
            step(24);
            if (i == 0 || i == 254 || i == 255 || i == 299)
                exp_at(0, "sat_loss", 0, 0, 1, 0, 0, (i + 1 > 255) ? 255 : i + 1);
        end

        for (int k = 0; k < 100 && q.size() != 0; k++) step(1);
        if (q.size() != 0) begin
            $display("FAIL drain pending=%0d want 0", q.size());
            n_miss += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
